// File: rtl/matmul_sequencer_if.sv
// Handshake, SRAM read/write and MAC control bundle between the matmul sequencer and its datapath.
// master = sequencer side, slave = SRAMs / MAC / top-level handshake side.
interface matmul_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              dut_valid;
  logic              dut_ready;
  logic [ADDR_W-1:0] input_rd_addr;
  logic [DATA_W-1:0] input_rd_data;
  logic [ADDR_W-1:0] weight_rd_addr;
  logic [DATA_W-1:0] weight_rd_data;
  logic              mac_en;
  logic              mac_first;
  logic [DATA_W-1:0] mac_acc;
  logic              result_wr_en;
  logic [ADDR_W-1:0] result_wr_addr;
  logic [DATA_W-1:0] result_wr_data;
  logic              dim_error;

  modport master (
    input  dut_valid, input_rd_data, weight_rd_data, mac_acc,
    output dut_ready, input_rd_addr, weight_rd_addr, mac_en, mac_first,
           result_wr_en, result_wr_addr, result_wr_data, dim_error
  );

  modport slave (
    output dut_valid, input_rd_data, weight_rd_data, mac_acc,
    input  dut_ready, input_rd_addr, weight_rd_addr, mac_en, mac_first,
           result_wr_en, result_wr_addr, result_wr_data, dim_error
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Matrix-multiply control sequencer: header check, then walks C[i][j] streaming K operand pairs to the MAC.
// Optional macro MATMUL_RESULT_HEADER_EN writes a {M,N} header word at result address 0 before the elements.
module matmul_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  matmul_sequencer_if.master bus
);
  localparam int DIM_W = DATA_W / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CAP, S_RHDR, S_DOT, S_DRAIN, S_WRT, S_DONE
  } state_t;

  state_t            state_q;
  logic              dut_ready_q;
  logic              dim_error_q;
  logic              mac_en_q;
  logic              mac_first_q;
  logic              wr_en_q;
  logic              hdr_sel_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic [ADDR_W-1:0] wt_addr_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] col_base_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DIM_W-1:0]  m_q;
  logic [DIM_W-1:0]  k_dim_q;
  logic [DIM_W-1:0]  n_q;
  logic [DIM_W-1:0]  i_q;
  logic [DIM_W-1:0]  j_q;
  logic [DIM_W-1:0]  k_q;

  logic [DIM_W-1:0]  m_d;
  logic [DIM_W-1:0]  ka_d;
  logic [DIM_W-1:0]  kb_d;
  logic [DIM_W-1:0]  n_d;
  logic              hdr_err_d;
  logic              last_k_d;
  logic              last_j_d;
  logic              last_elem_d;
  logic [ADDR_W-1:0] k_step_d;

  assign m_d         = bus.input_rd_data[DATA_W-1:DIM_W];
  assign ka_d        = bus.input_rd_data[DIM_W-1:0];
  assign kb_d        = bus.weight_rd_data[DATA_W-1:DIM_W];
  assign n_d         = bus.weight_rd_data[DIM_W-1:0];
  assign hdr_err_d   = (ka_d != kb_d) || (m_d == '0) || (ka_d == '0) || (n_d == '0);
  assign k_step_d    = ADDR_W'(k_dim_q);
  assign last_k_d    = (k_q == k_dim_q - DIM_W'(1));
  assign last_j_d    = (j_q == n_q - DIM_W'(1));
  assign last_elem_d = last_j_d && (i_q == m_q - DIM_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dut_ready_q <= 1'b0;
      dim_error_q <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      wr_en_q     <= 1'b0;
      hdr_sel_q   <= 1'b0;
      in_addr_q   <= '0;
      wt_addr_q   <= '0;
      row_base_q  <= '0;
      col_base_q  <= '0;
      wr_addr_q   <= '0;
      m_q         <= '0;
      k_dim_q     <= '0;
      n_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
    end else begin
      // Data lags the address by one cycle, so the MAC strobes trail the DOT state.
      mac_en_q    <= (state_q == S_DOT);
      mac_first_q <= (state_q == S_DOT) && (k_q == '0);
      wr_en_q     <= 1'b0;
      hdr_sel_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          dut_ready_q <= 1'b1;
          if (bus.dut_valid && dut_ready_q) begin
            dut_ready_q <= 1'b0;
            dim_error_q <= 1'b0;
            in_addr_q   <= '0;
            wt_addr_q   <= '0;
            state_q     <= S_HDR;
          end
        end

        S_HDR: state_q <= S_CAP;

        S_CAP: begin
          m_q        <= m_d;
          k_dim_q    <= ka_d;
          n_q        <= n_d;
          i_q        <= '0;
          j_q        <= '0;
          k_q        <= '0;
          row_base_q <= ADDR_W'(1);
          col_base_q <= ADDR_W'(1);
          wr_addr_q  <= '0;
          if (hdr_err_d) begin
            dim_error_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
`ifdef MATMUL_RESULT_HEADER_EN
            wr_en_q   <= 1'b1;
            hdr_sel_q <= 1'b1;
            state_q   <= S_RHDR;
`else
            in_addr_q <= ADDR_W'(1);
            wt_addr_q <= ADDR_W'(1);
            state_q   <= S_DOT;
`endif
          end
        end

`ifdef MATMUL_RESULT_HEADER_EN
        S_RHDR: begin
          wr_addr_q <= wr_addr_q + 1'b1;
          in_addr_q <= ADDR_W'(1);
          wt_addr_q <= ADDR_W'(1);
          state_q   <= S_DOT;
        end
`endif

        S_DOT: begin
          if (last_k_d) begin
            k_q     <= '0;
            state_q <= S_DRAIN;
          end else begin
            k_q       <= k_q + 1'b1;
            in_addr_q <= in_addr_q + 1'b1;
            wt_addr_q <= wt_addr_q + 1'b1;
          end
        end

        S_DRAIN: begin
          wr_en_q <= 1'b1;
          state_q <= S_WRT;
        end

        S_WRT: begin
          wr_addr_q <= wr_addr_q + 1'b1;
          if (last_elem_d) begin
            state_q <= S_DONE;
          end else if (last_j_d) begin
            // Next row: row base steps by K, column base wraps to B's first column.
            i_q        <= i_q + 1'b1;
            j_q        <= '0;
            row_base_q <= row_base_q + k_step_d;
            col_base_q <= ADDR_W'(1);
            in_addr_q  <= row_base_q + k_step_d;
            wt_addr_q  <= ADDR_W'(1);
            state_q    <= S_DOT;
          end else begin
            j_q        <= j_q + 1'b1;
            col_base_q <= col_base_q + k_step_d;
            in_addr_q  <= row_base_q;
            wt_addr_q  <= col_base_q + k_step_d;
            state_q    <= S_DOT;
          end
        end

        S_DONE: begin
          dut_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dut_ready      = dut_ready_q;
  assign bus.dim_error      = dim_error_q;
  assign bus.input_rd_addr  = in_addr_q;
  assign bus.weight_rd_addr = wt_addr_q;
  assign bus.mac_en         = mac_en_q;
  assign bus.mac_first      = mac_first_q;
  assign bus.result_wr_en   = wr_en_q;
  assign bus.result_wr_addr = wr_addr_q;
  // The accumulator only holds the complete sum in the WRT cycle, so the data path is a pass-through.
  assign bus.result_wr_data = !wr_en_q ? '0 : (hdr_sel_q ? {m_q, n_q} : bus.mac_acc);
endmodule
